// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: FSM state encoding, default
// vectors and trap cause codes.
package fetch_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Next-PC priority mux used when the held instruction is consumed:
// trap > mret > redirect > sequential PC+4.
// Build option: PC_MISALIGN_TRAP_EN turns a misaligned redirect target into
// an instruction-address-misaligned trap instead of silently aligning it.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  logic [XLEN-1:0] instr_pc,
    input  logic [XLEN-1:0] epc,
    input  logic            trap_req,
    input  logic [3:0]      trap_cause,
    input  logic            mret,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_next,
    output logic            trap_load,
    output logic [3:0]      cause_next
);

    // Priority selection of the next fetch address and trap bookkeeping.
    always_comb begin
        pc_next    = instr_pc + 32'd4;
        trap_load  = 1'b0;
        cause_next = trap_cause;
        if (trap_req) begin
            pc_next   = TRAP_VECTOR;
            trap_load = 1'b1;
        end else if (mret) begin
            pc_next = epc;
        end else if (redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (redirect_target[1:0] != 2'b00) begin
                pc_next    = TRAP_VECTOR;
                trap_load  = 1'b1;
                cause_next = CAUSE_MISALIGNED;
            end else begin
                pc_next = redirect_target;
            end
`else
            pc_next = word_align(redirect_target);
`endif
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and instruction fetch control for the RV32 core.
// Fetches over a req/ack handshake, holds the instruction while the datapath
// stalls, and picks the next PC on consume. Debug halt/resume included.
// Build option: PC_MISALIGN_TRAP_EN (see pc_next_sel).
//
// state | meaning
// BOOT  | first cycle out of reset, no request
// FETCH | imem_req high at pc, waiting for imem_ack
// ISSUE | instruction held valid until consumed (stall=0)
// HALT  | debug halt, pc held until resume
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic [3:0]      trap_cause,
    input  logic            mret,
    output logic [XLEN-1:0] epc,
    output logic [3:0]      cause,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [3:0]      cause_q, cause_d;

    logic [XLEN-1:0] sel_pc_next;
    logic            sel_trap_load;
    logic [3:0]      sel_cause_next;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_pc_next_sel (
        .instr_pc        (instr_pc_q),
        .epc             (epc_q),
        .trap_req        (trap_req),
        .trap_cause      (trap_cause),
        .mret            (mret),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_next         (sel_pc_next),
        .trap_load       (sel_trap_load),
        .cause_next      (sel_cause_next)
    );

    // FSM transitions and next values of all sequencer registers.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Everything except reset is ignored while stalled.
                if (!stall) begin
                    instr_valid_d = 1'b0;
                    pc_d          = sel_pc_next;
                    if (sel_trap_load) begin
                        epc_d   = instr_pc_q;
                        cause_d = sel_cause_next;
                    end
                    state_d = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous reset; an in-flight fetch is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            epc_q         <= '0;
            cause_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        halted      = (state_q == ST_HALT);
        imem_addr   = pc_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        instr_valid = instr_valid_q;
        epc         = epc_q;
        cause       = cause_q;
    end

endmodule
